// File: rtl/riscv_pkg.sv
// Shared RV core types: the retire trace record and the trace filter modes.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [4:0]      reg_addr;
      logic [XLEN-1:0] reg_data;
      logic [XLEN-1:0] mem_addr;
      logic [XLEN-1:0] mem_data;
      logic            mem_wrt;
      logic            mem_read;
   } retire_entry_t;

   typedef enum logic [1:0] {
      TR_ALL = 2'd0,
      TR_REG = 2'd1,
      TR_MEM = 2'd2,
      TR_OFF = 2'd3
   } trace_mode_e;

   // A retirement is a trace candidate only if it matches the selected filter.
   function automatic logic passFilter(trace_mode_e mode, logic [4:0] regAddr,
                                       logic memWrt, logic memRead);
      logic pass;
      pass = 1'b0;
      case (mode)
         TR_ALL:  pass = 1'b1;
         TR_REG:  pass = (regAddr != 5'd0);
         TR_MEM:  pass = memWrt | memRead;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// Generic single-clock FIFO; occupancy comes from free-running counters with one
// extra MSB so full and empty are distinguishable.
module rv_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wrCnt;
   logic [AW:0]      rdCnt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             doPush;
   logic             doPop;

   assign level_o = wrCnt - rdCnt;
   assign empty_o = (level_o == '0);
   assign full_o  = (level_o == (AW+1)'(DEPTH));
   assign doPop   = pop_i & ~empty_o;
   assign doPush  = push_i & (~full_o | doPop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wrCnt <= '0;
         rdCnt <= '0;
      end else begin
         if (doPush) wrCnt <= wrCnt + 1'b1;
         if (doPop)  rdCnt <= rdCnt + 1'b1;
      end
   end

   // Storage is deliberately not reset; only the counters define contents.
   always_ff @(posedge clk_i) begin
      if (doPush) mem[wrCnt[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = empty_o ? '0 : mem[rdCnt[AW-1:0]];

endmodule

// File: rtl/rv_retire_buffer.sv
// Retire-trace buffer: filters core retirements by mode, queues them for a
// valid/ready sink, and reports backpressure, drops and accepted-record counts.
module rv_retire_buffer
   import riscv_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int STALL_MARGIN = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     update_i,
   input  logic [XLEN-1:0]          pc_i,
   input  logic [XLEN-1:0]          instr_i,
   input  logic [4:0]               reg_addr_i,
   input  logic [XLEN-1:0]          reg_data_i,
   input  logic [XLEN-1:0]          mem_addr_i,
   input  logic [XLEN-1:0]          mem_data_i,
   input  logic                     mem_wrt_i,
   input  logic                     mem_read_i,
   input  logic [1:0]               mode_i,
   output logic                     stall_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output retire_entry_t            rec_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o,
   output logic [15:0]              drop_cnt_o,
   output logic [31:0]              retired_cnt_o
);

   localparam int LW = $clog2(DEPTH) + 1;

   retire_entry_t newRec;
   logic          candidate;
   logic          fifoFull;
   logic          fifoEmpty;
   logic          doPush;
   logic          doPop;
   logic          doDrop;
   logic [LW-1:0] levelNext;

   assign newRec = '{pc: pc_i, instr: instr_i, reg_addr: reg_addr_i,
                     reg_data: reg_data_i, mem_addr: mem_addr_i,
                     mem_data: mem_data_i, mem_wrt: mem_wrt_i,
                     mem_read: mem_read_i};

   assign candidate = update_i & passFilter(trace_mode_e'(mode_i), reg_addr_i,
                                            mem_wrt_i, mem_read_i);
   assign valid_o   = ~fifoEmpty;
   assign doPop     = valid_o & ready_i;
   assign doPush    = candidate & (~fifoFull | doPop);
   assign doDrop    = candidate & fifoFull & ~doPop;
   assign levelNext = level_o + LW'(doPush) - LW'(doPop);

   rv_sync_fifo #(
      .WIDTH ($bits(retire_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (doPush),
      .pop_i   (doPop),
      .wdata_i (newRec),
      .rdata_o (rec_o),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .level_o (level_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_o       <= 1'b0;
         overflow_o    <= 1'b0;
         drop_cnt_o    <= '0;
         retired_cnt_o <= '0;
      end else begin
         // Stall looks at the occupancy the FIFO will have after this edge.
         stall_o <= ((LW'(DEPTH) - levelNext) <= LW'(STALL_MARGIN));
         if (doDrop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
         end
         if (doPush) retired_cnt_o <= retired_cnt_o + 32'd1;
      end
   end

endmodule
